// File: rtl/char_health_ctrl.sv
// Player health sequencer: box-overlap contact detection, damage/heal arbitration,
// frame-counted invulnerability window and death signalling for the draw path.
module char_health_ctrl #(
  parameter int IFRAMES     = 60,
  parameter int CONTACT_DMG = 1,
  parameter int ATTACK_DMG  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_frame_tick,
  input  logic        i_game_start,
  input  logic [1:0]  i_game_active,
  input  logic [1:0]  i_char_class,
  input  logic [11:0] i_char_x,
  input  logic [11:0] i_char_y,
  input  logic [11:0] i_char_lng,
  input  logic [11:0] i_char_hgt,
  input  logic [11:0] i_boss_x,
  input  logic [11:0] i_boss_y,
  input  logic [11:0] i_boss_lng,
  input  logic [11:0] i_boss_hgt,
  input  logic        i_atk_hit,
  input  logic        i_heal,
  output logic [3:0]  o_char_hp,
  output logic [3:0]  o_max_hp,
  output logic        o_invuln,
  output logic        o_blink,
  output logic        o_hit_pulse,
  output logic        o_char_dead,
  output logic [1:0]  o_state,
  output logic [7:0]  o_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIVE  = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } state_t;

  localparam logic [3:0] LP_CONTACT = 4'(CONTACT_DMG);
  localparam logic [3:0] LP_ATTACK  = 4'(ATTACK_DMG);
  localparam logic [7:0] LP_IFRAMES = 8'(IFRAMES);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_hp, w_hp_nxt;
  logic [3:0]  r_max_hp, w_max_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_hit, w_hit_nxt;
  logic        r_dead, w_dead_nxt;
  logic        r_overlap_q;

  // 13-bit box ends so a box near the 12-bit limit cannot wrap into a false overlap
  logic [12:0] w_char_xe, w_char_ye, w_boss_xe, w_boss_ye;
  logic        w_nonzero, w_overlap;

  assign w_char_xe = {1'b0, i_char_x} + {1'b0, i_char_lng};
  assign w_char_ye = {1'b0, i_char_y} + {1'b0, i_char_hgt};
  assign w_boss_xe = {1'b0, i_boss_x} + {1'b0, i_boss_lng};
  assign w_boss_ye = {1'b0, i_boss_y} + {1'b0, i_boss_hgt};
  // A zero-size box would otherwise pass the strict compares when it sits inside the other box
  assign w_nonzero = (i_char_lng != 12'd0) && (i_char_hgt != 12'd0) &&
                     (i_boss_lng != 12'd0) && (i_boss_hgt != 12'd0);
  assign w_overlap = w_nonzero &&
                     ({1'b0, i_char_x} < w_boss_xe) && ({1'b0, i_boss_x} < w_char_xe) &&
                     ({1'b0, i_char_y} < w_boss_ye) && ({1'b0, i_boss_y} < w_char_ye);

  logic [3:0] w_contact_dmg, w_attack_dmg, w_dmg, w_class_hp;
  logic       w_active;

  assign w_contact_dmg = r_overlap_q ? LP_CONTACT : 4'd0;
  assign w_attack_dmg  = i_atk_hit   ? LP_ATTACK  : 4'd0;
  assign w_dmg         = (w_contact_dmg > w_attack_dmg) ? w_contact_dmg : w_attack_dmg;
  assign w_active      = (i_game_active == 2'd1);

  always_comb begin
    case (i_char_class)
      2'd0:    w_class_hp = 4'd6;
      2'd1:    w_class_hp = 4'd5;
      default: w_class_hp = 4'd4;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hp_nxt    = r_hp;
    w_max_nxt   = r_max_hp;
    w_cnt_nxt   = r_cnt;
    w_hit_nxt   = 1'b0;
    w_dead_nxt  = 1'b0;
    if (i_game_start) begin
      w_max_nxt   = w_class_hp;
      w_hp_nxt    = w_class_hp;
      w_cnt_nxt   = 8'd0;
      w_state_nxt = ALIVE;
    end else begin
      case (r_state)
        ALIVE: begin
          if (w_active) begin
            if (w_dmg != 4'd0) begin
              w_hit_nxt = 1'b1;
              if (r_hp <= w_dmg) begin
                w_hp_nxt    = 4'd0;
                w_dead_nxt  = 1'b1;
                w_state_nxt = DEAD;
              end else begin
                w_hp_nxt    = r_hp - w_dmg;
                w_cnt_nxt   = LP_IFRAMES;
                w_state_nxt = INVULN;
              end
            end else if (i_heal && (r_hp < r_max_hp)) begin
              w_hp_nxt = r_hp + 4'd1;
            end
          end
        end
        INVULN: begin
          if (w_active) begin
            if (i_heal && (r_hp < r_max_hp)) begin
              w_hp_nxt = r_hp + 4'd1;
            end
            if (i_frame_tick) begin
              if (r_cnt <= 8'd1) begin
                w_cnt_nxt   = 8'd0;
                w_state_nxt = ALIVE;
              end else begin
                w_cnt_nxt = r_cnt - 8'd1;
              end
            end
          end
        end
        DEAD:    w_hp_nxt = 4'd0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_hp        <= 4'd0;
      r_max_hp    <= 4'd0;
      r_cnt       <= 8'd0;
      r_hit       <= 1'b0;
      r_dead      <= 1'b0;
      r_overlap_q <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hp        <= w_hp_nxt;
      r_max_hp    <= w_max_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hit       <= w_hit_nxt;
      r_dead      <= w_dead_nxt;
      r_overlap_q <= w_overlap;
    end
  end

  assign o_char_hp   = r_hp;
  assign o_max_hp    = r_max_hp;
  assign o_invuln    = (r_state == INVULN);
  assign o_blink     = (r_state == INVULN) & r_cnt[2];
  assign o_hit_pulse = r_hit;
  assign o_char_dead = r_dead;
  assign o_state     = r_state;
  assign o_cnt       = r_cnt;

endmodule

// File: tb/tb_char_health_ctrl.sv
// Directed bench for char_health_ctrl: reset, contact/attack damage, invulnerability,
// heal, pause, death and mid-round reset, checked with immediate assertions.
module tb_char_health_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        game_start = 1'b0;
  logic [1:0]  game_active = 2'd1;
  logic [1:0]  char_class = 2'd0;
  logic [11:0] char_x = 12'd0, char_y = 12'd0, char_lng = 12'd10, char_hgt = 12'd10;
  logic [11:0] boss_x = 12'd500, boss_y = 12'd500, boss_lng = 12'd64, boss_hgt = 12'd64;
  logic        atk_hit = 1'b0;
  logic        heal = 1'b0;
  logic [3:0]  char_hp, max_hp;
  logic        invuln, blink, hit_pulse, char_dead;
  logic [1:0]  state;
  logic [7:0]  cnt;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_ALIVE = 2'd1, S_INVULN = 2'd2, S_DEAD = 2'd3;

  char_health_ctrl #(.IFRAMES(60), .CONTACT_DMG(1), .ATTACK_DMG(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_frame_tick(frame_tick), .i_game_start(game_start),
    .i_game_active(game_active), .i_char_class(char_class),
    .i_char_x(char_x), .i_char_y(char_y), .i_char_lng(char_lng), .i_char_hgt(char_hgt),
    .i_boss_x(boss_x), .i_boss_y(boss_y), .i_boss_lng(boss_lng), .i_boss_hgt(boss_hgt),
    .i_atk_hit(atk_hit), .i_heal(heal),
    .o_char_hp(char_hp), .o_max_hp(max_hp), .o_invuln(invuln), .o_blink(blink),
    .o_hit_pulse(hit_pulse), .o_char_dead(char_dead), .o_state(state), .o_cnt(cnt)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic set_boss(input logic [11:0] x, input logic [11:0] y);
    boss_x = x;
    boss_y = y;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hp"}, 16'(char_hp), 16'd0);
    chk({tag, "_max"}, 16'(max_hp), 16'd0);
    chk({tag, "_state"}, 16'(state), 16'(S_IDLE));
    chk({tag, "_inv"}, 16'(invuln), 16'd0);
    chk({tag, "_blink"}, 16'(blink), 16'd0);
    chk({tag, "_hit"}, 16'(hit_pulse), 16'd0);
    chk({tag, "_dead"}, 16'(char_dead), 16'd0);
  endtask

  initial begin
    // Reset
    repeat (3) step();
    rst = 1'b0;
    step();
    chk_reset_vals("rst");
    atk_hit = 1'b1; heal = 1'b1;
    step();
    atk_hit = 1'b0; heal = 1'b0;
    chk("idle_ignore_hp", 16'(char_hp), 16'd0);
    chk("idle_ignore_state", 16'(state), 16'(S_IDLE));

    // Start round, class 0
    char_class = 2'd0; game_start = 1'b1;
    step();
    game_start = 1'b0;
    chk("start0_hp", 16'(char_hp), 16'd6);
    chk("start0_max", 16'(max_hp), 16'd6);
    chk("start0_state", 16'(state), 16'(S_ALIVE));
    chk("start0_inv", 16'(invuln), 16'd0);
    heal = 1'b1;
    step();
    heal = 1'b0;
    chk("heal_at_max", 16'(char_hp), 16'd6);

    // Held contact overlap
    char_x = 12'd100; char_y = 12'd100; char_lng = 12'd32; char_hgt = 12'd48;
    boss_lng = 12'd64; boss_hgt = 12'd64; set_boss(12'd120, 12'd130);
    step();
    chk("ovl_n1_hp", 16'(char_hp), 16'd6);
    chk("ovl_n1_hit", 16'(hit_pulse), 16'd0);
    step();
    chk("ovl_n2_hp", 16'(char_hp), 16'd5);
    chk("ovl_n2_hit", 16'(hit_pulse), 16'd1);
    chk("ovl_n2_inv", 16'(invuln), 16'd1);
    chk("ovl_n2_cnt", 16'(cnt), 16'd60);
    chk("ovl_n2_blink", 16'(blink), 16'd1);
    step();
    chk("ovl_n3_hit", 16'(hit_pulse), 16'd0);
    chk("ovl_n3_hp", 16'(char_hp), 16'd5);

    frames(56);
    chk("if56_cnt", 16'(cnt), 16'd4);
    chk("if56_blink", 16'(blink), 16'd1);
    frames(1);
    chk("if57_blink", 16'(blink), 16'd0);
    frames(2);
    chk("if59_state", 16'(state), 16'(S_INVULN));
    chk("if59_hp", 16'(char_hp), 16'd5);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("if60_state", 16'(state), 16'(S_ALIVE));
    chk("if60_hp", 16'(char_hp), 16'd5);
    chk("if60_inv", 16'(invuln), 16'd0);
    step();
    chk("rehit_hp", 16'(char_hp), 16'd4);
    chk("rehit_pulse", 16'(hit_pulse), 16'd1);
    chk("rehit_state", 16'(state), 16'(S_INVULN));

    // Pause during INVULN: counter and HP frozen, heals discarded
    game_active = 2'd2;
    for (int i = 0; i < 10; i++) begin
      frame_tick = 1'b1; heal = 1'b1;
      step();
      frame_tick = 1'b0; heal = 1'b0;
      step();
    end
    chk("pause_cnt", 16'(cnt), 16'd60);
    chk("pause_hp", 16'(char_hp), 16'd4);
    chk("pause_state", 16'(state), 16'(S_INVULN));
    game_active = 2'd1;
    heal = 1'b1;
    step();
    heal = 1'b0;
    chk("inv_heal_hp", 16'(char_hp), 16'd5);
    atk_hit = 1'b1;
    step();
    atk_hit = 1'b0;
    chk("inv_atk_hp", 16'(char_hp), 16'd5);
    chk("inv_atk_hit", 16'(hit_pulse), 16'd0);

    // Edge-touching boxes: char right edge 132 == boss_x
    set_boss(12'd132, 12'd100);
    frames(60);
    chk("touch_state", 16'(state), 16'(S_ALIVE));
    step(); step();
    chk("touch_hp", 16'(char_hp), 16'd5);
    chk("touch_hit", 16'(hit_pulse), 16'd0);

    // Contact and attack together: larger damage once
    set_boss(12'd120, 12'd130);
    step();
    chk("combo_pre_hp", 16'(char_hp), 16'd5);
    atk_hit = 1'b1;
    step();
    atk_hit = 1'b0;
    chk("combo_hp", 16'(char_hp), 16'd3);
    chk("combo_hit", 16'(hit_pulse), 16'd1);

    // Heal together with attack: hit wins
    set_boss(12'd500, 12'd500);
    frames(60);
    chk("hh_pre_state", 16'(state), 16'(S_ALIVE));
    chk("hh_pre_hp", 16'(char_hp), 16'd3);
    heal = 1'b1; atk_hit = 1'b1;
    step();
    heal = 1'b0; atk_hit = 1'b0;
    chk("hh_hp", 16'(char_hp), 16'd1);
    chk("hh_state", 16'(state), 16'(S_INVULN));

    // Restart with class 2 (also from INVULN), then die
    char_class = 2'd2; game_start = 1'b1;
    step();
    game_start = 1'b0;
    chk("start2_hp", 16'(char_hp), 16'd4);
    chk("start2_max", 16'(max_hp), 16'd4);
    chk("start2_state", 16'(state), 16'(S_ALIVE));
    chk("start2_cnt", 16'(cnt), 16'd0);
    atk_hit = 1'b1;
    step();
    atk_hit = 1'b0;
    chk("c2_hit_hp", 16'(char_hp), 16'd2);
    frames(60);
    atk_hit = 1'b1;
    step();
    atk_hit = 1'b0;
    chk("death_hp", 16'(char_hp), 16'd0);
    chk("death_pulse", 16'(char_dead), 16'd1);
    chk("death_hit", 16'(hit_pulse), 16'd1);
    chk("death_state", 16'(state), 16'(S_DEAD));
    step();
    chk("death_pulse_end", 16'(char_dead), 16'd0);
    chk("death_hit_end", 16'(hit_pulse), 16'd0);
    heal = 1'b1;
    step();
    heal = 1'b0;
    chk("dead_heal_hp", 16'(char_hp), 16'd0);
    atk_hit = 1'b1;
    step();
    atk_hit = 1'b0;
    chk("dead_atk_hp", 16'(char_hp), 16'd0);
    chk("dead_atk_hit", 16'(hit_pulse), 16'd0);
    frames(2);
    chk("dead_hold_state", 16'(state), 16'(S_DEAD));
    game_start = 1'b1;
    step();
    game_start = 1'b0;
    chk("restart_hp", 16'(char_hp), 16'd4);
    chk("restart_state", 16'(state), 16'(S_ALIVE));

    // Reset mid-INVULN
    atk_hit = 1'b1;
    step();
    atk_hit = 1'b0;
    chk("pre_rst_inv", 16'(invuln), 16'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_vals("midrst");

    // Class 1, zero-width character inside the boss box
    char_class = 2'd1; game_start = 1'b1;
    char_x = 12'd130; char_y = 12'd140; char_lng = 12'd0; char_hgt = 12'd10;
    set_boss(12'd120, 12'd130);
    step();
    game_start = 1'b0;
    chk("start1_hp", 16'(char_hp), 16'd5);
    chk("start1_max", 16'(max_hp), 16'd5);
    step(); step(); step();
    chk("zero_size_hp", 16'(char_hp), 16'd5);
    chk("zero_size_state", 16'(state), 16'(S_ALIVE));

    // Class 3 maps to 4
    char_class = 2'd3; game_start = 1'b1;
    step();
    game_start = 1'b0;
    chk("start3_max", 16'(max_hp), 16'd4);
    chk("start3_hp", 16'(char_hp), 16'd4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
